conf_cal_ctrl: RTL and testbench
================================

CONF_CAL_CTRL -- requirements
Module: conf_cal_ctrl

Interface
REQ-001 Parameter CONF_BITS, default 4: width of every configuration code.
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles waited after each code change before the comparator is sampled; legal range 1..255.
REQ-003 Parameter INVALID_LIMIT, default 3: consecutive invalid comparator samples tolerated before error.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  reset; synchronous and active-low.
REQ-006 START  input  1  one-cycle request to begin calibration; honoured only in IDLE, LOCKED or FAIL.
REQ-007 ABORT  input  1  stop calibration; return to IDLE.
REQ-008 O_INVU  input  1  comparator output, up-inverter side.
REQ-009 O_INVD  input  1  comparator output, down-inverter side.
REQ-010 INVU_PCONF  output  CONF_BITS  up-inverter PMOS strength code.
REQ-011 INVU_NCONF  output  CONF_BITS  up-inverter NMOS strength code.
REQ-012 INVD_PCONF  output  CONF_BITS  down-inverter PMOS code; always the bitwise complement of INVU_PCONF.
REQ-013 INVD_NCONF  output  CONF_BITS  down-inverter NMOS code; always the bitwise complement of INVU_NCONF.
REQ-014 BUSY  output  1  high in INIT, SETTLE and SAMPLE.
REQ-015 DONE  output  1  high in LOCKED only.
REQ-016 ERR  output  1  high in FAIL only.

Function
REQ-017 States: IDLE, INIT, SETTLE, SAMPLE, LOCKED, FAIL. A phase flag selects P (PMOS) or N (NMOS) tuning.
REQ-018 START in IDLE, LOCKED or FAIL moves the block to INIT, which lasts one cycle.
- INIT loads PCODE and NCODE to all-ones, sets phase P, clears the last-direction register to NONE and clears the invalid counter.
REQ-019 SETTLE lasts exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
REQ-020 SAMPLE lasts one cycle and samples {O_INVU,O_INVD}.
- 2'b10 = direction DOWN: the active code decrements.
- 2'b01 = direction UP: the active code increments.
- The update is visible on the outputs on the cycle after SAMPLE.
REQ-021 Each tuning iteration therefore takes SETTLE_CYCLES+1 cycles.
REQ-022 Reversal: in SAMPLE, a valid direction opposite to a non-NONE last direction is a reversal.
- No code step is applied.
- In phase P: switch to phase N, set last direction to NONE, go to SETTLE.
- In phase N: go to LOCKED.
REQ-023 A valid non-reversal sample records its direction as the last direction.
REQ-024 Invalid sample (2'b00 or 2'b11):
- No step is applied and the last direction is unchanged.
- The invalid counter increments and the block returns to SETTLE.
- When the counter reaches INVALID_LIMIT, the block goes to FAIL.
- Any valid sample clears the counter.
REQ-025 Saturation: a step that would take the active code below 0 or above 2^CONF_BITS-1 is not applied; the block goes to FAIL instead.
REQ-026 Codes are held unchanged in LOCKED, FAIL and IDLE.
REQ-027 ABORT in any state except IDLE sends the block to IDLE on the next edge with codes held; ABORT has priority over START.
REQ-028 START while BUSY is ignored.
REQ-029 Outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-030 RST_N low at a clock edge forces, regardless of state or START/ABORT:
- state IDLE and phase P;
- INVU_PCONF and INVU_NCONF all-ones;
- INVD_PCONF and INVD_NCONF all-zeros;
- BUSY, DONE and ERR low;
- settle and invalid counters zero;
- last direction NONE.
REQ-031 Reset in the middle of a calibration discards all progress; a fresh START is required afterwards.

Structure
REQ-032 Shared package conf_cal_pkg holds the state enum, the direction enum (NONE/UP/DOWN) and the comparator code constants 2'b10 and 2'b01.
REQ-033 The settle countdown is implemented in one sub-module, conf_cal_settle_timer, with inputs load and enable and output expired.

Verification (CONF_BITS=4, SETTLE_CYCLES=2, INVALID_LIMIT=3)
REQ-034 Reset with START high -> IDLE; INVU codes 4'hF, INVD codes 4'h0; BUSY, DONE and ERR all 0.
REQ-035 START, then comparator 10,10,10,01 in phase P and 10,10,01 in phase N -> INVU_PCONF=4'hC, INVD_PCONF=4'h3, INVU_NCONF=4'hD, INVD_NCONF=4'h2, DONE=1; iterations spaced 3 cycles apart.
REQ-036 Comparator held at 10 -> INVU_PCONF steps down to 4'h0, the 16th DOWN sample gives ERR=1 with codes held at 0/F, and BUSY drops the same cycle.
REQ-037 Comparator 11,11,10 -> no fail and PCONF=4'hE; comparator 00,11,00 -> ERR=1 after the third sample.
REQ-038 ABORT asserted during SETTLE -> IDLE next cycle, BUSY=0, codes unchanged; START pulsed while BUSY -> no effect.
REQ-039 RST_N low mid-phase-N -> codes return to 4'hF/4'h0 on the next edge and DONE stays 0.

Source files
------------

// File: rtl/conf_cal_pkg.sv
// Shared types and constants for the inverter-strength calibration controller.
package conf_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } cal_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } cal_dir_e;

  typedef enum logic {
    PHASE_P = 1'b0,
    PHASE_N = 1'b1
  } cal_phase_e;

  // Comparator codes {O_INVU, O_INVD}; anything else is an invalid sample.
  localparam logic [1:0] CMP_DOWN = 2'b10;
  localparam logic [1:0] CMP_UP   = 2'b01;

  // States in which a calibration run is in progress.
  function automatic logic is_busy_state(input cal_state_e s);
    return (s == ST_INIT) || (s == ST_SETTLE) || (s == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/conf_cal_settle_timer.sv
// Settle countdown: after load, expired rises on the SETTLE_CYCLES-th enabled cycle.
module conf_cal_settle_timer #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Reload on entry to a settle period, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (enable && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == 8'd0);

endmodule

// File: rtl/conf_cal_ctrl.sv
// Calibration controller: walks the PMOS code, then the NMOS code, of an
// inverter pair until the comparator reverses direction, then locks.
// START and ABORT are plain levels sampled on every rising edge; there is no
// valid/ready handshake on this block. DBG_STATE mirrors the state register.
module conf_cal_ctrl
  import conf_cal_pkg::*;
#(
  parameter int CONF_BITS     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int INVALID_LIMIT = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 O_INVU,
  input  logic                 O_INVD,
  output logic [CONF_BITS-1:0] INVU_PCONF,
  output logic [CONF_BITS-1:0] INVU_NCONF,
  output logic [CONF_BITS-1:0] INVD_PCONF,
  output logic [CONF_BITS-1:0] INVD_NCONF,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output cal_state_e           DBG_STATE
);

  localparam int                 INV_W       = $clog2(INVALID_LIMIT + 1);
  localparam logic [INV_W-1:0]   INV_LIMIT_V = INV_W'(INVALID_LIMIT);
  localparam logic [CONF_BITS-1:0] CODE_MAX  = {CONF_BITS{1'b1}};

  cal_state_e           state_q, state_d;
  cal_phase_e           phase_q, phase_d;
  cal_dir_e             last_dir_q, last_dir_d;
  logic [INV_W-1:0]     inv_cnt_q, inv_cnt_d;
  logic [CONF_BITS-1:0] pcode_q, pcode_d;
  logic [CONF_BITS-1:0] ncode_q, ncode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 timer_load;
  logic                 timer_expired;

  logic [1:0]           cmp;
  cal_dir_e             samp_dir;
  logic                 samp_valid;
  logic                 reversal;
  logic [CONF_BITS-1:0] active_code;
  logic                 saturate;
  logic [INV_W-1:0]     inv_next;
  logic                 inv_limit_hit;

  // Reload the settle timer whenever a settle period is about to begin.
  assign timer_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  conf_cal_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (CLK),
    .rst_n  (RST_N),
    .load   (timer_load),
    .enable (state_q == ST_SETTLE),
    .expired(timer_expired)
  );

  // Decode the comparator sample and the conditions it leads to.
  always_comb begin
    cmp         = {O_INVU, O_INVD};
    samp_dir    = DIR_NONE;
    if (cmp == CMP_DOWN)    samp_dir = DIR_DOWN;
    else if (cmp == CMP_UP) samp_dir = DIR_UP;
    samp_valid  = (samp_dir != DIR_NONE);
    reversal    = samp_valid && (last_dir_q != DIR_NONE) && (samp_dir != last_dir_q);
    active_code = (phase_q == PHASE_P) ? pcode_q : ncode_q;
    saturate    = samp_valid && !reversal &&
                  (((samp_dir == DIR_DOWN) && (active_code == '0)) ||
                   ((samp_dir == DIR_UP)   && (active_code == CODE_MAX)));
    inv_next      = inv_cnt_q + INV_W'(1);
    inv_limit_hit = !samp_valid && (inv_next >= INV_LIMIT_V);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ABORT wins over everything including START.
  always_comb begin
    state_d = state_q;
    if (ABORT) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_LOCKED, ST_FAIL: if (START) state_d = ST_INIT;
        ST_INIT:   state_d = ST_SETTLE;
        ST_SETTLE: if (timer_expired) state_d = ST_SAMPLE;
        ST_SAMPLE: begin
          if (!samp_valid)   state_d = inv_limit_hit ? ST_FAIL : ST_SETTLE;
          else if (reversal) state_d = (phase_q == PHASE_P) ? ST_SETTLE : ST_LOCKED;
          else if (saturate) state_d = ST_FAIL;
          else               state_d = ST_SETTLE;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output flags, registered from the next state so they line up with it.
  always_comb begin
    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_LOCKED);
    err_d  = (state_d == ST_FAIL);
  end

  // Code, phase, direction and invalid-count updates; frozen on ABORT.
  always_comb begin
    pcode_d    = pcode_q;
    ncode_d    = ncode_q;
    phase_d    = phase_q;
    last_dir_d = last_dir_q;
    inv_cnt_d  = inv_cnt_q;
    if (!ABORT) begin
      if (state_q == ST_INIT) begin
        pcode_d    = CODE_MAX;
        ncode_d    = CODE_MAX;
        phase_d    = PHASE_P;
        last_dir_d = DIR_NONE;
        inv_cnt_d  = '0;
      end else if (state_q == ST_SAMPLE) begin
        if (!samp_valid) begin
          inv_cnt_d = inv_next;
        end else begin
          inv_cnt_d = '0;
          if (reversal) begin
            if (phase_q == PHASE_P) begin
              phase_d    = PHASE_N;
              last_dir_d = DIR_NONE;
            end
          end else begin
            last_dir_d = samp_dir;
            if (!saturate) begin
              if (phase_q == PHASE_P) begin
                pcode_d = (samp_dir == DIR_DOWN) ? pcode_q - 1'b1 : pcode_q + 1'b1;
              end else begin
                ncode_d = (samp_dir == DIR_DOWN) ? ncode_q - 1'b1 : ncode_q + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Datapath and output flag registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pcode_q    <= CODE_MAX;
      ncode_q    <= CODE_MAX;
      phase_q    <= PHASE_P;
      last_dir_q <= DIR_NONE;
      inv_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pcode_q    <= pcode_d;
      ncode_q    <= ncode_d;
      phase_q    <= phase_d;
      last_dir_q <= last_dir_d;
      inv_cnt_q  <= inv_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign INVU_PCONF = pcode_q;
  assign INVU_NCONF = ncode_q;
  assign INVD_PCONF = ~pcode_q;
  assign INVD_NCONF = ~ncode_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_conf_cal_ctrl.sv
// Bench for conf_cal_ctrl: directed scenarios plus random traffic, checked
// against an iteration-level reference model through an expected queue.
module tb_conf_cal_ctrl;
  import conf_cal_pkg::*;

  localparam int CB   = 4;
  localparam int SC   = 2;
  localparam int IL   = 3;
  localparam int W    = 4 * CB + 3;
  localparam int CMAX = (1 << CB) - 1;

  logic          CLK, RST_N, START, ABORT, O_INVU, O_INVD;
  logic [CB-1:0] INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF;
  logic          BUSY, DONE, ERR;
  cal_state_e    DBG_STATE;

  conf_cal_ctrl #(
    .CONF_BITS    (CB),
    .SETTLE_CYCLES(SC),
    .INVALID_LIMIT(IL)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .O_INVU    (O_INVU),
    .O_INVD    (O_INVD),
    .INVU_PCONF(INVU_PCONF),
    .INVU_NCONF(INVU_NCONF),
    .INVD_PCONF(INVD_PCONF),
    .INVD_NCONF(INVD_NCONF),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    RST_N  = 1'b0;
    START  = 1'b0;
    ABORT  = 1'b0;
    O_INVU = 1'b0;
    O_INVD = 1'b0;
  end

  // ---------------- reference model ----------------
  // m_mode: 0 idle, 1 running, 2 locked, 3 failed.
  // m_t: 0 = the one init cycle; 1..SC settle cycles; SC+1 = sample cycle.
  int m_mode, m_p, m_n, m_phase, m_last, m_inv, m_t;

  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_bad;
  string        tag;

  initial begin
    m_mode = 0; m_p = CMAX; m_n = CMAX; m_phase = 0; m_last = 0; m_inv = 0; m_t = 0;
    n_cmp = 0; n_bad = 0; tag = "init";
  end

  task automatic model_sample(input logic [1:0] cmp);
    int dir;
    int code;
    dir = (cmp == 2'b10) ? -1 : (cmp == 2'b01) ? 1 : 0;
    if (dir == 0) begin
      m_inv = m_inv + 1;
      if (m_inv >= IL) m_mode = 3;
    end else begin
      m_inv = 0;
      if (m_last != 0 && dir == -m_last) begin
        if (m_phase == 0) begin
          m_phase = 1;
          m_last  = 0;
        end else begin
          m_mode = 2;
        end
      end else begin
        m_last = dir;
        code = ((m_phase == 0) ? m_p : m_n) + dir;
        if (code < 0 || code > CMAX) m_mode = 3;
        else if (m_phase == 0)       m_p = code;
        else                         m_n = code;
      end
    end
  endtask

  task automatic model_edge(input logic rst_n, input logic start, input logic abort,
                            input logic [1:0] cmp);
    if (!rst_n) begin
      m_mode = 0; m_p = CMAX; m_n = CMAX; m_phase = 0; m_last = 0; m_inv = 0; m_t = 0;
    end else if (m_mode == 1) begin
      if (abort) begin
        m_mode = 0;
      end else if (m_t == 0) begin
        m_p = CMAX; m_n = CMAX; m_phase = 0; m_last = 0; m_inv = 0; m_t = 1;
      end else if (m_t == SC + 1) begin
        model_sample(cmp);
        m_t = 1;
      end else begin
        m_t = m_t + 1;
      end
    end else if (abort) begin
      m_mode = 0;
    end else if (start) begin
      m_mode = 1;
      m_t    = 0;
    end
  endtask

  function automatic logic [W-1:0] model_snapshot();
    logic [CB-1:0] pv;
    logic [CB-1:0] nv;
    pv = CB'(m_p);
    nv = CB'(m_n);
    return {pv, nv, ~pv, ~nv, (m_mode == 1), (m_mode == 2), (m_mode == 3)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rst_n, input logic start, input logic abort,
                     input logic [1:0] cmp);
    @(negedge CLK);
    #1;
    RST_N = rst_n;
    START = start;
    ABORT = abort;
    {O_INVU, O_INVD} = cmp;
    @(posedge CLK);
    model_edge(rst_n, start, abort, cmp);
    exp_q.push_back(model_snapshot());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  // START pulse followed by the init cycle.
  task automatic kick();
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  // One full tuning iteration with the comparator held at cmp.
  task automatic iter(input logic [1:0] cmp);
    for (int i = 0; i < SC + 1; i++) cyc(1'b1, 1'b0, 1'b0, cmp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF, BUSY, DONE, ERR};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s @%0t: got {up,un,dp,dn,busy,done,err}=%h required %h",
                 tag, $time, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int bias;
    int r;
    logic [1:0] cmp;

    tag = "reset_with_start";
    cyc(1'b0, 1'b1, 1'b0, 2'b10);
    cyc(1'b0, 1'b0, 1'b0, 2'b00);
    idle_cycles(2);

    tag = "lock_sequence";
    kick();
    iter(2'b10); iter(2'b10); iter(2'b10); iter(2'b01);
    iter(2'b10); iter(2'b10); iter(2'b01);
    idle_cycles(3);

    tag = "saturate_down";
    kick();
    for (int i = 0; i < 16; i++) iter(2'b10);
    idle_cycles(3);

    tag = "invalid_samples";
    kick();
    iter(2'b11); iter(2'b11); iter(2'b10);
    iter(2'b00); iter(2'b11); iter(2'b00);
    idle_cycles(3);

    tag = "abort_in_settle";
    kick();
    iter(2'b10);
    cyc(1'b1, 1'b0, 1'b1, 2'b10);
    idle_cycles(3);

    tag = "start_while_busy";
    kick();
    cyc(1'b1, 1'b1, 1'b0, 2'b10);
    cyc(1'b1, 1'b1, 1'b0, 2'b10);
    cyc(1'b1, 1'b0, 1'b0, 2'b10);
    iter(2'b10);
    cyc(1'b1, 1'b1, 1'b1, 2'b00);
    idle_cycles(2);

    tag = "reset_mid_phase_n";
    kick();
    iter(2'b10); iter(2'b01); iter(2'b10);
    cyc(1'b0, 1'b0, 1'b0, 2'b10);
    idle_cycles(3);

    tag = "random";
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) bias = $urandom_range(5, 95);
      r = $urandom_range(0, 99);
      if (r < bias)    cmp = 2'b10;
      else if (r < 94) cmp = 2'b01;
      else             cmp = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      cyc(($urandom_range(0, 249) != 0),
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 79) == 0),
          cmp);
    end

    @(negedge CLK);
    #2;
    tag = "drain";
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
